scan_sequencer: RTL and testbench
=================================

// Module: scan_sequencer
// PURPOSE
// Parametrised top-level sequencer for the mapping datapath. On a start edge it reads the robot
// position, then steps through one frame of laser scans. Each scan goes round-robin to one of
// NUM_ENGINES ray-tracing (Bresenham) engines. The sequencer drains all engines before it
// returns to the draw/idle phase. It can run one frame per start edge, or run frames continuously.
// PARAMETERS
// NUM_ENGINES      2     ray-tracing engines dispatched round-robin (1..8)
// MEM_LATENCY      1     read-latency cycles of the scan/position memory (1..4)
// SCAN_CNT_W       16    width of scans_processed counter
// WATCHDOG_CYCLES  4096  stall limit for WAIT_SLOT/DRAIN (only with SCAN_WATCHDOG_EN)
// PORTS
// clock                input   1               rising-edge system clock
// reset_n              input   1               asynchronous, active-low reset
// start                input   1               level input; its rising edge starts a frame
// continuous           input   1               1: start the next frame right after frame_done
// scan_done            input   1               scan memory: current frame exhausted
// simulation_done      input   1               scan memory: no more frames
// address_enable       output  1               advance scan address (1-cycle pulse)
// address_reset        output  1               reset scan address
// position_enable      output  1               latch robot position
// engine_start         output  NUM_ENGINES     one-hot start pulse to the engines
// engine_busy          input   NUM_ENGINES     per-engine busy
// engine_select        output  $clog2(NUM_ENGINES) (min 1)  round-robin pointer
// use_engine_indices   output  1               grid address mux: 1 = engine indices, 0 = VGA indices
// zero_occupancy_grid  output  1               clear occupancy grid
// occupancy_busy       input   1               grid clear/update in progress
// frame_done           output  1               1-cycle pulse when a frame has fully drained
// scans_processed      output  SCAN_CNT_W      count of dispatched scans, saturating
// watchdog_error       output  1               sticky stall flag
// BEHAVIOUR
// - Reset values: FSM=CLEAR, all outputs 0, rr pointer 0, counters 0, start history 2'b00.
// - start_edge: 2-flop history of start; edge = history==2'b01. Only sampled in IDLE.
// - CLEAR: address_reset=1, zero_occupancy_grid=1 for exactly 1 cycle -> IDLE.
// - IDLE: start_edge && !occupancy_busy -> WAIT_POS, else stay. An edge seen while busy is dropped.
// - WAIT_POS: stays MEM_LATENCY cycles (down-counter) -> READ_POSITION.
// - READ_POSITION: position_enable=1 for 1 cycle -> FETCH_SCAN.
// - FETCH_SCAN: address_enable=1 for 1 cycle -> WAIT_SCAN.
// - WAIT_SCAN: stays MEM_LATENCY cycles, then: scan_done||simulation_done -> DRAIN, else DISPATCH.
// - DISPATCH: if !engine_busy[ptr]: engine_start[ptr]=1 for 1 cycle, scans_processed++,
//   ptr wraps NUM_ENGINES-1 -> 0, go FETCH_SCAN. Else -> WAIT_SLOT.
// - WAIT_SLOT: wait for !engine_busy[ptr], then perform the DISPATCH action in the same cycle.
//   Only engine[ptr] is considered; no skipping to another free engine.
// - Engines assert busy the cycle after start. The FETCH/WAIT_SCAN gap (>=2 cycles) guarantees
//   that busy is visible before that engine is revisited, including NUM_ENGINES=1.
// - DRAIN: when engine_busy==0 && !occupancy_busy: frame_done=1 for 1 cycle.
//   Then continuous && !simulation_done -> WAIT_POS; otherwise -> IDLE.
// - use_engine_indices = (state in DISPATCH/WAIT_SLOT/DRAIN) || |engine_busy.
// - engine_select = ptr (registered).
// - scans_processed saturates at all-ones. It clears only in CLEAR.
// - scan_done and simulation_done are ignored outside WAIT_SCAN.
// - reset_n low in any state returns immediately to reset values, including mid-dispatch.
//   No pulse is completed.
// - Illegal state encoding -> CLEAR.
// CONFIGURATION
// SCAN_WATCHDOG_EN defined:
//   - A counter runs while in WAIT_SLOT or DRAIN and clears on any other state.
//   - When it reaches WATCHDOG_CYCLES: watchdog_error<=1 (sticky until reset_n), FSM -> IDLE,
//     no frame_done pulse.
// SCAN_WATCHDOG_EN undefined: no counter, watchdog_error tied 0, WAIT_SLOT/DRAIN wait indefinitely.
// TESTING
// 1. NUM_ENGINES=2, MEM_LATENCY=1, 4 scans then scan_done, engines busy 5 cycles
//    -> engine_start one-hot sequence 01,10,01,10; scans_processed=4; one frame_done; back to IDLE.
// 2. engine_busy[0] held high for 20 cycles when ptr=0
//    -> FSM stays in WAIT_SLOT, no engine_start; dispatch in the cycle engine 0 drops busy.
// 3. continuous=1, 3 frames, simulation_done with the 3rd scan_done
//    -> 3 frame_done pulses, 3 position_enable pulses, final state IDLE.
// 4. start pulsed while occupancy_busy=1 in IDLE -> no transition. A later edge with busy=0 starts a frame.
// 5. reset_n low for 1 cycle during DISPATCH -> all outputs 0 asynchronously; CLEAR pulse follows release.
// 6. SCAN_WATCHDOG_EN, WATCHDOG_CYCLES=16, engine stuck busy
//    -> watchdog_error=1 after 16 cycles, FSM to IDLE, no frame_done.

Source files
------------

// File: rtl/scan_sequencer.sv
// Frame sequencer for the mapping datapath: position read, scan fetch, round-robin engine dispatch, drain.
// Optional stall watchdog on WAIT_SLOT/DRAIN is built when SCAN_WATCHDOG_EN is defined.
module scan_sequencer #(
   parameter int  NUM_ENGINES     = 2,
   parameter int  MEM_LATENCY     = 1,
   parameter int  SCAN_CNT_W      = 16,
   parameter int  WATCHDOG_CYCLES = 4096,
   localparam int PTR_W           = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   continuous,
   input  logic                   scan_done,
   input  logic                   simulation_done,
   output logic                   address_enable,
   output logic                   address_reset,
   output logic                   position_enable,
   output logic [NUM_ENGINES-1:0] engine_start,
   input  logic [NUM_ENGINES-1:0] engine_busy,
   output logic [PTR_W-1:0]       engine_select,
   output logic                   use_engine_indices,
   output logic                   zero_occupancy_grid,
   input  logic                   occupancy_busy,
   output logic                   frame_done,
   output logic [SCAN_CNT_W-1:0]  scans_processed,
   output logic                   watchdog_error,
   output logic [3:0]             state_dbg
);

   typedef enum logic [3:0] {
      S_CLEAR     = 4'd0,
      S_IDLE      = 4'd1,
      S_WAIT_POS  = 4'd2,
      S_READ_POS  = 4'd3,
      S_FETCH     = 4'd4,
      S_WAIT_SCAN = 4'd5,
      S_DISPATCH  = 4'd6,
      S_WAIT_SLOT = 4'd7,
      S_DRAIN     = 4'd8
   } state_t;

   localparam int               LAT_W      = 3;
   localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(MEM_LATENCY - 1);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_ENGINES - 1);

   if (NUM_ENGINES < 1 || NUM_ENGINES > 8) begin : g_bad_engines
      $error("scan_sequencer: NUM_ENGINES must be 1..8");
   end
   if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
      $error("scan_sequencer: MEM_LATENCY must be 1..4");
   end
   if (WATCHDOG_CYCLES < 1) begin : g_bad_watchdog
      $error("scan_sequencer: WATCHDOG_CYCLES must be positive");
   end

   state_t                  state_q, state_d;
   logic [1:0]              start_hist_q, start_hist_d;
   logic [LAT_W-1:0]        lat_q, lat_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [SCAN_CNT_W-1:0]   scans_q, scans_d;
   logic                    sim_end_q, sim_end_d;
   logic                    address_enable_q, address_enable_d;
   logic                    address_reset_q, address_reset_d;
   logic                    position_enable_q, position_enable_d;
   logic                    zero_grid_q, zero_grid_d;
   logic                    frame_done_q, frame_done_d;
   logic                    use_idx_q, use_idx_d;
   logic [NUM_ENGINES-1:0]  engine_start_q, engine_start_d;

   logic start_edge, slot_free, drained, lat_done, dispatch_now, frame_end, wd_trip;

   assign start_edge   = (start_hist_q == 2'b01);
   assign slot_free    = !engine_busy[ptr_q];
   assign drained      = (engine_busy == '0) && !occupancy_busy;
   assign lat_done     = (lat_q == '0);
   assign dispatch_now = ((state_q == S_DISPATCH) || (state_q == S_WAIT_SLOT)) && slot_free;
   assign frame_end    = (state_q == S_DRAIN) && drained;

`ifdef SCAN_WATCHDOG_EN
   localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            wd_err_q, wd_err_d;
   logic            stalled;

   assign stalled = ((state_q == S_WAIT_SLOT) && !slot_free) || ((state_q == S_DRAIN) && !drained);
   assign wd_trip = stalled && (wd_q == WD_W'(WATCHDOG_CYCLES - 1));

   always_comb begin
      wd_d     = stalled ? wd_q + 1'b1 : '0;
      wd_err_d = wd_err_q | wd_trip;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wd_q     <= '0;
         wd_err_q <= 1'b0;
      end else begin
         wd_q     <= wd_d;
         wd_err_q <= wd_err_d;
      end
   end

   assign watchdog_error = wd_err_q;
`else
   assign wd_trip        = 1'b0;
   assign watchdog_error = 1'b0;
`endif

   // Every output is a flop so that reset forces all of them low, including the CLEAR strobes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q           <= S_CLEAR;
         start_hist_q      <= 2'b00;
         lat_q             <= '0;
         ptr_q             <= '0;
         scans_q           <= '0;
         sim_end_q         <= 1'b0;
         address_enable_q  <= 1'b0;
         address_reset_q   <= 1'b0;
         position_enable_q <= 1'b0;
         zero_grid_q       <= 1'b0;
         frame_done_q      <= 1'b0;
         use_idx_q         <= 1'b0;
         engine_start_q    <= '0;
      end else begin
         state_q           <= state_d;
         start_hist_q      <= start_hist_d;
         lat_q             <= lat_d;
         ptr_q             <= ptr_d;
         scans_q           <= scans_d;
         sim_end_q         <= sim_end_d;
         address_enable_q  <= address_enable_d;
         address_reset_q   <= address_reset_d;
         position_enable_q <= position_enable_d;
         zero_grid_q       <= zero_grid_d;
         frame_done_q      <= frame_done_d;
         use_idx_q         <= use_idx_d;
         engine_start_q    <= engine_start_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR:     state_d = S_IDLE;
         S_IDLE:      if (start_edge && !occupancy_busy) state_d = S_WAIT_POS;
         S_WAIT_POS:  if (lat_done) state_d = S_READ_POS;
         S_READ_POS:  state_d = S_FETCH;
         S_FETCH:     state_d = S_WAIT_SCAN;
         S_WAIT_SCAN: begin
            if (lat_done) state_d = (scan_done || simulation_done) ? S_DRAIN : S_DISPATCH;
         end
         S_DISPATCH:  state_d = slot_free ? S_FETCH : S_WAIT_SLOT;
         // Only the engine under the pointer is eligible; a free neighbour is never taken instead.
         S_WAIT_SLOT: begin
            if (slot_free)    state_d = S_FETCH;
            else if (wd_trip) state_d = S_IDLE;
         end
         S_DRAIN: begin
            if (drained)      state_d = (continuous && !sim_end_q) ? S_WAIT_POS : S_IDLE;
            else if (wd_trip) state_d = S_IDLE;
         end
         default:     state_d = S_CLEAR;
      endcase
   end

   always_comb begin
      address_reset_d   = (state_q == S_CLEAR);
      zero_grid_d       = (state_q == S_CLEAR);
      position_enable_d = (state_q == S_READ_POS);
      address_enable_d  = (state_q == S_FETCH);
      frame_done_d      = frame_end;
      use_idx_d         = (state_q == S_DISPATCH) || (state_q == S_WAIT_SLOT) ||
                          (state_q == S_DRAIN) || (|engine_busy);
      engine_start_d    = '0;
      ptr_d             = ptr_q;
      scans_d           = scans_q;
      if (dispatch_now) begin
         engine_start_d = NUM_ENGINES'(1) << ptr_q;
         ptr_d          = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
         if (scans_q != {SCAN_CNT_W{1'b1}}) scans_d = scans_q + 1'b1;
      end
      if (state_q == S_CLEAR) scans_d = '0;

      // Memory-wait down-counter: preloaded outside the wait states, counts down inside them.
      if (((state_q == S_WAIT_POS) || (state_q == S_WAIT_SCAN)) && !lat_done) lat_d = lat_q - 1'b1;
      else                                                                     lat_d = LAT_RELOAD;

      // End-of-simulation is captured with the scan verdict so DRAIN decides on it later.
      sim_end_d = sim_end_q;
      if ((state_q == S_WAIT_SCAN) && lat_done) sim_end_d = simulation_done;

      start_hist_d = {start_hist_q[0], start};
   end

   assign address_enable      = address_enable_q;
   assign address_reset       = address_reset_q;
   assign position_enable     = position_enable_q;
   assign zero_occupancy_grid = zero_grid_q;
   assign frame_done          = frame_done_q;
   assign use_engine_indices  = use_idx_q;
   assign engine_start        = engine_start_q;
   assign engine_select       = ptr_q;
   assign scans_processed     = scans_q;
   assign state_dbg           = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: frame dispatch, slot stall, continuous frames, busy-gated start,
// mid-dispatch reset, and the stall watchdog when SCAN_WATCHDOG_EN is defined.
module tb_scan_sequencer;

   localparam int NE       = 2;
   localparam int SCW      = 16;
   localparam int WDC      = 16;
   localparam int BUSY_LEN = 5;
`ifdef SCAN_WATCHDOG_EN
   localparam int STALL    = 10;
`else
   localparam int STALL    = 20;
`endif

   localparam logic [3:0] S_CLEAR = 4'd0, S_IDLE = 4'd1, S_WAIT_POS = 4'd2, S_FETCH = 4'd4,
                          S_DISPATCH = 4'd6, S_WAIT_SLOT = 4'd7;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b0, continuous = 1'b0, scan_done = 1'b0, simulation_done = 1'b0;
   logic            occupancy_busy = 1'b0;
   logic [NE-1:0]   model_busy, force_busy = '0, engine_busy;
   logic            address_enable, address_reset, position_enable, use_engine_indices;
   logic            zero_occupancy_grid, frame_done, watchdog_error;
   logic [NE-1:0]   engine_start;
   logic [0:0]      engine_select;
   logic [SCW-1:0]  scans_processed;
   logic [3:0]      state_dbg;

   int              vectors = 0, miscompares = 0;
   int              start_cnt = 0, fd_cnt = 0, pe_cnt = 0;
   logic [NE-1:0]   exp_q[$];
   logic [NE-1:0]   got_q[$];
   int              busy_cnt[NE];
   logic [NE-1:0]   pend = '0;
   int              exp_scans = 0;

   scan_sequencer #(
      .NUM_ENGINES(NE), .MEM_LATENCY(1), .SCAN_CNT_W(SCW), .WATCHDOG_CYCLES(WDC)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .continuous(continuous),
      .scan_done(scan_done), .simulation_done(simulation_done),
      .address_enable(address_enable), .address_reset(address_reset),
      .position_enable(position_enable), .engine_start(engine_start),
      .engine_busy(engine_busy), .engine_select(engine_select),
      .use_engine_indices(use_engine_indices), .zero_occupancy_grid(zero_occupancy_grid),
      .occupancy_busy(occupancy_busy), .frame_done(frame_done),
      .scans_processed(scans_processed), .watchdog_error(watchdog_error), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL global_timeout sim time exceeded, required finish earlier");
      $fatal(1);
   end

   // ---------------- engine model: busy from the cycle after start, BUSY_LEN cycles ----------------
   initial for (int i = 0; i < NE; i++) busy_cnt[i] = 0;

   always @(negedge clock) begin
      for (int i = 0; i < NE; i++) begin
         pend[i] <= engine_start[i];
         if (pend[i])              busy_cnt[i] <= BUSY_LEN;
         else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
      end
   end

   always_comb begin
      model_busy = '0;
      for (int i = 0; i < NE; i++) model_busy[i] = (busy_cnt[i] != 0);
   end
   assign engine_busy = model_busy | force_busy;

   // ---------------- pulse monitor ----------------
   always @(posedge clock) begin
      if (reset_n) begin
         if (|engine_start) begin
            got_q.push_back(engine_start);
            start_cnt <= start_cnt + 1;
         end
         if (frame_done)      fd_cnt <= fd_cnt + 1;
         if (position_enable) pe_cnt <= pe_cnt + 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic drive_scans(input int n, input bit sim_end, output bit ok);
      int sbase, fbase;
      bit hit;
      sbase = start_cnt;
      fbase = fd_cnt;
      hit   = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (start_cnt >= sbase + n) begin hit = 1'b1; break; end
      end
      scan_done       = 1'b1;
      simulation_done = sim_end;
      ok = hit;
      hit = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (fd_cnt > fbase) begin hit = 1'b1; break; end
      end
      scan_done       = 1'b0;
      simulation_done = 1'b0;
      ok = ok & hit;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [7+NE-1:0] outs;
      reset_n = 1'b0;
      idle_cycles(3);
      outs = {address_enable, address_reset, position_enable, zero_occupancy_grid, frame_done,
              use_engine_indices, watchdog_error, engine_start};
      vectors++;
      if (outs !== '0) begin
         miscompares++; $display("FAIL reset_outputs got %h exp 0", outs);
      end
      vectors++;
      if ({state_dbg, engine_select, scans_processed} !== {S_CLEAR, 1'b0, 16'h0000}) begin
         miscompares++;
         $display("FAIL reset_state got state %0d sel %0d scans %0d exp 0/0/0", state_dbg, engine_select, scans_processed);
      end
      reset_n = 1'b1;
      @(negedge clock);
      vectors++;
      if ({address_reset, zero_occupancy_grid, state_dbg} !== {2'b11, S_IDLE}) begin
         miscompares++;
         $display("FAIL clear_pulse got ar %b zg %b state %0d exp 1 1 %0d", address_reset, zero_occupancy_grid, state_dbg, S_IDLE);
      end
      @(negedge clock);
      vectors++;
      if ({address_reset, zero_occupancy_grid, state_dbg} !== {2'b00, S_IDLE}) begin
         miscompares++;
         $display("FAIL clear_single got ar %b zg %b state %0d exp 0 0 %0d", address_reset, zero_occupancy_grid, state_dbg, S_IDLE);
      end
   endtask

   task automatic test_frame();
      bit ok;
      int fbase, pbase;
      got_q.delete();
      exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
      fbase = fd_cnt;
      pbase = pe_cnt;
      start = 1'b1;
      drive_scans(4, 1'b0, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL frame_timeout got no completion exp frame_done"); end
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++; $display("FAIL frame_start_count got %0d exp %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++; $display("FAIL frame_onehot[%0d] got %b exp %b", i, got_q[i], exp_q[i]);
         end
      end
      exp_scans = 4;
      vectors++;
      if (scans_processed !== SCW'(exp_scans)) begin
         miscompares++; $display("FAIL frame_scans got %0d exp %0d", scans_processed, exp_scans);
      end
      vectors++;
      if ({fd_cnt - fbase, pe_cnt - pbase} !== {32'd1, 32'd1}) begin
         miscompares++; $display("FAIL frame_pulses got fd %0d pe %0d exp 1 1", fd_cnt - fbase, pe_cnt - pbase);
      end
      vectors++;
      if (state_dbg !== S_IDLE) begin
         miscompares++; $display("FAIL frame_idle got %0d exp %0d", state_dbg, S_IDLE);
      end
      start = 1'b0;
      idle_cycles(3);
   endtask

   task automatic test_wait_slot();
      bit ok, seen;
      vectors++;
      if (engine_select !== 1'b0) begin
         miscompares++; $display("FAIL slot_ptr got %0d exp 0", engine_select);
      end
      force_busy = 2'b01;
      start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (state_dbg == S_WAIT_SLOT) begin seen = 1'b1; break; end
      end
      vectors++;
      if (!seen) begin miscompares++; $display("FAIL slot_enter got state %0d exp %0d", state_dbg, S_WAIT_SLOT); end
      for (int c = 0; c < STALL; c++) begin
         @(negedge clock);
         vectors++;
         if ({state_dbg, engine_start} !== {S_WAIT_SLOT, 2'b00}) begin
            miscompares++;
            $display("FAIL slot_hold[%0d] got state %0d start %b exp %0d 00", c, state_dbg, engine_start, S_WAIT_SLOT);
         end
      end
      force_busy = 2'b00;
      @(negedge clock);
      vectors++;
      if ({state_dbg, engine_start} !== {S_FETCH, 2'b01}) begin
         miscompares++;
         $display("FAIL slot_release got state %0d start %b exp %0d 01", state_dbg, engine_start, S_FETCH);
      end
      drive_scans(2, 1'b0, ok);
      exp_scans += 2;
      vectors++;
      if ({ok, scans_processed, watchdog_error} !== {1'b1, SCW'(exp_scans), 1'b0}) begin
         miscompares++;
         $display("FAIL slot_finish got ok %b scans %0d wd %b exp 1 %0d 0", ok, scans_processed, watchdog_error, exp_scans);
      end
      start = 1'b0;
      idle_cycles(3);
   endtask

   task automatic test_continuous();
      bit ok;
      int fbase, pbase;
      fbase = fd_cnt;
      pbase = pe_cnt;
      continuous = 1'b1;
      start = 1'b1;
      for (int f = 0; f < 3; f++) begin
         drive_scans(2, f == 2, ok);
         vectors++;
         if (!ok) begin miscompares++; $display("FAIL cont_frame[%0d] got timeout exp completion", f); end
      end
      exp_scans += 6;
      @(negedge clock);
      vectors++;
      if ({fd_cnt - fbase, pe_cnt - pbase} !== {32'd3, 32'd3}) begin
         miscompares++; $display("FAIL cont_pulses got fd %0d pe %0d exp 3 3", fd_cnt - fbase, pe_cnt - pbase);
      end
      vectors++;
      if ({state_dbg, scans_processed} !== {S_IDLE, SCW'(exp_scans)}) begin
         miscompares++;
         $display("FAIL cont_end got state %0d scans %0d exp %0d %0d", state_dbg, scans_processed, S_IDLE, exp_scans);
      end
      continuous = 1'b0;
      start = 1'b0;
      idle_cycles(3);
   endtask

   task automatic test_busy_start();
      bit ok, seen;
      occupancy_busy = 1'b1;
      idle_cycles(2);
      start = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         vectors++;
         if (state_dbg !== S_IDLE) begin
            miscompares++; $display("FAIL busy_hold[%0d] got %0d exp %0d", c, state_dbg, S_IDLE);
         end
      end
      start = 1'b0;
      idle_cycles(2);
      occupancy_busy = 1'b0;
      idle_cycles(2);
      start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (state_dbg == S_WAIT_POS) begin seen = 1'b1; break; end
      end
      vectors++;
      if (!seen) begin miscompares++; $display("FAIL busy_later_edge got state %0d exp %0d", state_dbg, S_WAIT_POS); end
      drive_scans(1, 1'b0, ok);
      exp_scans += 1;
      vectors++;
      if ({ok, scans_processed} !== {1'b1, SCW'(exp_scans)}) begin
         miscompares++; $display("FAIL busy_frame got ok %b scans %0d exp 1 %0d", ok, scans_processed, exp_scans);
      end
      start = 1'b0;
      idle_cycles(3);
   endtask

   task automatic test_reset_mid_dispatch();
      logic [7+NE-1:0] outs;
      bit seen;
      start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (state_dbg == S_DISPATCH) begin seen = 1'b1; break; end
      end
      vectors++;
      if (!seen) begin miscompares++; $display("FAIL mid_enter got state %0d exp %0d", state_dbg, S_DISPATCH); end
      reset_n = 1'b0;
      start = 1'b0;
      #1;
      outs = {address_enable, address_reset, position_enable, zero_occupancy_grid, frame_done,
              use_engine_indices, watchdog_error, engine_start};
      vectors++;
      if ({outs, state_dbg, scans_processed, engine_select} !== {9'h000, S_CLEAR, 16'h0000, 1'b0}) begin
         miscompares++;
         $display("FAIL mid_async got outs %h state %0d scans %0d sel %0d exp 0 %0d 0 0", outs, state_dbg, scans_processed, engine_select, S_CLEAR);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      vectors++;
      if ({address_reset, zero_occupancy_grid, engine_start, state_dbg} !== {2'b11, 2'b00, S_IDLE}) begin
         miscompares++;
         $display("FAIL mid_clear got ar %b zg %b start %b state %0d exp 1 1 00 %0d", address_reset, zero_occupancy_grid, engine_start, state_dbg, S_IDLE);
      end
      exp_scans = 0;
      idle_cycles(3);
   endtask

`ifdef SCAN_WATCHDOG_EN
   task automatic test_watchdog();
      int fbase, cnt;
      bit seen;
      fbase = fd_cnt;
      force_busy = '1;
      idle_cycles(2);
      start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (state_dbg == S_WAIT_SLOT) begin seen = 1'b1; break; end
      end
      cnt = seen ? 1 : 0;
      for (int c = 0; c < 100 && seen; c++) begin
         @(negedge clock);
         if (state_dbg != S_WAIT_SLOT) break;
         cnt++;
      end
      vectors++;
      if (cnt != WDC) begin miscompares++; $display("FAIL wd_cycles got %0d exp %0d", cnt, WDC); end
      vectors++;
      if ({state_dbg, watchdog_error, fd_cnt - fbase} !== {S_IDLE, 1'b1, 32'd0}) begin
         miscompares++;
         $display("FAIL wd_trip got state %0d wd %b fd %0d exp %0d 1 0", state_dbg, watchdog_error, fd_cnt - fbase, S_IDLE);
      end
      force_busy = '0;
      start = 1'b0;
      idle_cycles(4);
      vectors++;
      if (watchdog_error !== 1'b1) begin miscompares++; $display("FAIL wd_sticky got %b exp 1", watchdog_error); end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (watchdog_error !== 1'b0) begin miscompares++; $display("FAIL wd_reset got %b exp 0", watchdog_error); end
      @(negedge clock);
      reset_n = 1'b1;
      idle_cycles(3);
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_frame();
      test_wait_slot();
      test_continuous();
      test_busy_start();
      test_reset_mid_dispatch();
`ifdef SCAN_WATCHDOG_EN
      test_watchdog();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
